// File: rtl/sa_inst_sequencer.sv
// Command FIFO + hold-timer sequencer driving the systolic array instruction/din buses.
// Optional build macro SA_SEQ_STATS_EN adds stat_inst_count / stat_busy_cycles outputs.
module sa_inst_sequencer #(
    parameter int INST_BITS          = 20,
    parameter int OPCODE_BITS        = 4,
    parameter int DIN_BITS           = 128,
    parameter int DOUT_BITS          = 320,
    parameter int FIFO_DEPTH         = 8,
    parameter int IDLE_CYCLE         = 1,
    parameter int WRITE_DATA_CYCLE   = 1,
    parameter int WRITE_WEIGHT_CYCLE = 1,
    parameter int LOAD_DATA_CYCLE    = 1,
    parameter int LOAD_WEIGHT_CYCLE  = 1,
    parameter int MAT_MUL_CYCLE      = 32,
    parameter int WRITE_RESULT_CYCLE = 1,
    parameter int READ_UB_CYCLE      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [INST_BITS-1:0] cmd_inst,
    input  logic [DIN_BITS-1:0]  cmd_din,
    output logic [INST_BITS-1:0] sa_instruction,
    output logic [DIN_BITS-1:0]  sa_din,
    input  logic [DOUT_BITS-1:0] sa_dout,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DOUT_BITS-1:0] rd_data,
    output logic                 busy,
    output logic                 err_opcode
`ifdef SA_SEQ_STATS_EN
    ,
    output logic [31:0]          stat_inst_count,
    output logic [31:0]          stat_busy_cycles
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLE = max2(max2(max2(IDLE_CYCLE, WRITE_DATA_CYCLE),
                                         max2(WRITE_WEIGHT_CYCLE, LOAD_DATA_CYCLE)),
                                    max2(max2(LOAD_WEIGHT_CYCLE, MAT_MUL_CYCLE),
                                         max2(WRITE_RESULT_CYCLE, READ_UB_CYCLE)));
    localparam int CW = $clog2(MAX_CYCLE) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_IDLE         = OPCODE_BITS'(0),
        OP_WRITE_DATA   = OPCODE_BITS'(1),
        OP_WRITE_WEIGHT = OPCODE_BITS'(2),
        OP_LOAD_DATA    = OPCODE_BITS'(3),
        OP_LOAD_WEIGHT  = OPCODE_BITS'(4),
        OP_MAT_MUL      = OPCODE_BITS'(5),
        OP_MAT_MUL_ACC  = OPCODE_BITS'(6),
        OP_WRITE_RESULT = OPCODE_BITS'(7),
        OP_READ_UB      = OPCODE_BITS'(8)
    } opcode_t;

    function automatic logic [CW-1:0] hold_of(input logic [OPCODE_BITS-1:0] op);
        case (op)
            OP_IDLE:         hold_of = CW'(IDLE_CYCLE - 1);
            OP_WRITE_DATA:   hold_of = CW'(WRITE_DATA_CYCLE - 1);
            OP_WRITE_WEIGHT: hold_of = CW'(WRITE_WEIGHT_CYCLE - 1);
            OP_LOAD_DATA:    hold_of = CW'(LOAD_DATA_CYCLE - 1);
            OP_LOAD_WEIGHT:  hold_of = CW'(LOAD_WEIGHT_CYCLE - 1);
            OP_MAT_MUL:      hold_of = CW'(MAT_MUL_CYCLE - 1);
            OP_MAT_MUL_ACC:  hold_of = CW'(MAT_MUL_CYCLE - 1);
            OP_WRITE_RESULT: hold_of = CW'(WRITE_RESULT_CYCLE - 1);
            OP_READ_UB:      hold_of = CW'(READ_UB_CYCLE - 1);
            default:         hold_of = '0;
        endcase
    endfunction

    logic [INST_BITS-1:0]   fifo_inst [FIFO_DEPTH];
    logic [DIN_BITS-1:0]    fifo_din  [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   empty, full, push, pop, capture, stall, illegal, last;
    logic [INST_BITS-1:0]   head_inst;
    logic [OPCODE_BITS-1:0] head_op, cur_op;
    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [INST_BITS-1:0]   inst_d;
    logic [DIN_BITS-1:0]    din_d;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign busy      = !empty || (state != S_IDLE);
    assign head_inst = fifo_inst[rd_ptr[AW-1:0]];
    assign head_op   = head_inst[INST_BITS-1 -: OPCODE_BITS];
    assign cur_op    = sa_instruction[INST_BITS-1 -: OPCODE_BITS];
    assign illegal   = head_op > OP_READ_UB;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr[AW-1:0]] <= cmd_inst;
            fifo_din[wr_ptr[AW-1:0]]  <= cmd_din;
        end
    end

    // A READ_UB may not issue while its capture could overwrite unconsumed rd_data,
    // including the cycle in which the previous READ_UB is itself capturing.
    always_comb begin
        state_d = state;
        inst_d  = sa_instruction;
        din_d   = sa_din;
        cnt_d   = cnt;
        pop     = 1'b0;
        last    = (state == S_HOLD) && (cnt == '0);
        capture = last && (cur_op == OP_READ_UB);
        stall   = (head_op == OP_READ_UB) && (capture || (rd_valid && !rd_ready));
        case (state)
            S_IDLE: pop = !empty && !stall;
            S_HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else if (!empty && !stall) begin
                    pop = 1'b1;
                end else begin
                    inst_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            state_d = S_HOLD;
            cnt_d   = hold_of(head_op);
            if (illegal) begin
                inst_d = '0;
                din_d  = '0;
            end else begin
                inst_d = head_inst;
                din_d  = fifo_din[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            sa_instruction <= '0;
            sa_din         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            err_opcode     <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            sa_instruction <= inst_d;
            sa_din         <= din_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pop && illegal) err_opcode <= 1'b1;
            if (capture) begin
                rd_valid <= 1'b1;
                rd_data  <= sa_dout;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

`ifdef SA_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_inst_count  <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (pop && stat_inst_count != '1) stat_inst_count <= stat_inst_count + 32'd1;
            if (state == S_HOLD && stat_busy_cycles != '1) stat_busy_cycles <= stat_busy_cycles + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Self-checking bench for sa_inst_sequencer: directed scenarios plus a randomized
// run compared against a transaction-level queue model.
module tb_sa_inst_sequencer;
    localparam int IB    = 20;
    localparam int DB    = 128;
    localparam int OB    = 320;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IB-1:0] cmd_inst;
    logic [DB-1:0] cmd_din;
    logic [IB-1:0] sa_instruction;
    logic [DB-1:0] sa_din;
    logic [OB-1:0] sa_dout;
    logic          rd_valid;
    logic          rd_ready;
    logic [OB-1:0] rd_data;
    logic          busy;
    logic          err_opcode;

    always #5 clk = ~clk;

    sa_inst_sequencer #(
        .INST_BITS(IB), .DIN_BITS(DB), .DOUT_BITS(OB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_inst(cmd_inst), .cmd_din(cmd_din), .sa_instruction(sa_instruction),
        .sa_din(sa_din), .sa_dout(sa_dout), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .busy(busy), .err_opcode(err_opcode)
    );

    typedef struct {
        logic [IB-1:0] inst;
        logic [DB-1:0] din;
    } cmd_t;

    // Reference model: a command queue plus the instruction on the bus and how many
    // bus cycles it still owns (0 = bus idle).
    cmd_t          q[$];
    logic [IB-1:0] m_inst;
    logic [DB-1:0] m_din;
    int            m_left;
    bit            m_read;
    logic          m_rdv;
    logic [OB-1:0] m_rdd;
    logic          m_err;

    int compared   = 0;
    int mismatched = 0;

    function automatic int cycles_of(input int op);
        if (op == 5 || op == 6) return 32;
        if (op == 8) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_inst = '0; m_din = '0; m_left = 0; m_read = 0;
        m_rdv = 1'b0; m_rdd = '0; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit   cap, accept, blocked, issue;
        int   op;
        cmd_t h;
        cap     = (m_left == 1) && m_read;
        accept  = cmd_valid && (q.size() < DEPTH);
        blocked = 0;
        if (q.size() > 0) begin
            h = q[0];
            if (h.inst[19:16] == 4'd8) blocked = cap || (m_rdv && !rd_ready);
        end
        issue = (m_left <= 1) && (q.size() > 0) && !blocked;
        if (cap) begin
            m_rdv = 1'b1;
            m_rdd = sa_dout;
        end else if (m_rdv && rd_ready) begin
            m_rdv = 1'b0;
        end
        if (issue) begin
            h  = q.pop_front();
            op = int'(h.inst[19:16]);
            if (op > 8) begin
                m_inst = '0; m_din = '0; m_left = 1; m_read = 0; m_err = 1'b1;
            end else begin
                m_inst = h.inst; m_din = h.din; m_left = cycles_of(op); m_read = (op == 8);
            end
        end else if (m_left == 1) begin
            m_inst = '0; m_left = 0; m_read = 0;
        end else if (m_left > 1) begin
            m_left--;
        end
        if (accept) begin
            h.inst = cmd_inst;
            h.din  = cmd_din;
            q.push_back(h);
        end
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; cmd_din = '0;
        rd_ready = 1'b0; sa_dout = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL reset_inst: got %h want 0", sa_instruction); end
        compared++; if (sa_din !== '0) begin mismatched++; $display("FAIL reset_din: got %h want 0", sa_din); end
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        compared++; if (rd_data !== '0) begin mismatched++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (err_opcode !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err_opcode); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_single_write();
        logic [DB-1:0] din;
        for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(i);
        cmd_valid = 1'b1; cmd_inst = 20'h10500; cmd_din = din;
        tick();
        cmd_valid = 1'b0;
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL single_t0: got %h want 0", sa_instruction); end
        tick();
        compared++; if (sa_instruction !== 20'h10500) begin mismatched++; $display("FAIL single_t1_inst: got %h want 10500", sa_instruction); end
        compared++; if (sa_din !== din) begin mismatched++; $display("FAIL single_t1_din: got %h want %h", sa_din, din); end
        tick();
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL single_t2_inst: got %h want 0", sa_instruction); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_t2_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        cmd_valid = 1'b1; cmd_inst = 20'h50102; cmd_din = '0;
        tick();
        cmd_inst = 20'h70304;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (sa_instruction === 20'h50102 && n < 40) begin n++; tick(); end
        compared++; if (n !== 32) begin mismatched++; $display("FAIL b2b_matmul_len: got %0d want 32", n); end
        compared++; if (sa_instruction !== 20'h70304) begin mismatched++; $display("FAIL b2b_successor: got %h want 70304", sa_instruction); end
        tick();
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL b2b_after: got %h want 0", sa_instruction); end
    endtask

    task automatic test_fifo_full();
        int waited;
        cmd_valid = 1'b1; cmd_inst = 20'h50000; cmd_din = '0;
        tick();
        for (int i = 0; i < 8; i++) begin
            cmd_inst = 20'h10000 | 20'(i); cmd_din = DB'(i);
            compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL fill_ready_%0d: got %b want 1", i, cmd_ready); end
            tick();
        end
        compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
        cmd_inst = 20'h100AA;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 100) begin tick(); waited++; end
        compared++; if (waited !== 25) begin mismatched++; $display("FAIL full_wait: got %0d cycles want 25", waited); end
        tick();
        cmd_valid = 1'b0;
        waited = 0;
        while (busy === 1'b1 && waited < 200) begin tick(); waited++; end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL full_drain: busy got %b want 0", busy); end
    endtask

    task automatic test_read_ub();
        logic [OB-1:0] ab, cd;
        ab = {40{8'hAB}}; cd = {40{8'hCD}};
        rd_ready = 1'b0; sa_dout = ab;
        cmd_valid = 1'b1; cmd_inst = 20'h81000; cmd_din = '1;
        tick();
        cmd_inst = 20'h81100;
        tick();
        cmd_valid = 1'b0;
        compared++; if (sa_instruction !== 20'h81000) begin mismatched++; $display("FAIL rd1_c1: got %h want 81000", sa_instruction); end
        tick();
        compared++; if (sa_instruction !== 20'h81000) begin mismatched++; $display("FAIL rd1_c2: got %h want 81000", sa_instruction); end
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL rd1_early_valid: got %b want 0", rd_valid); end
        tick();
        sa_dout = cd;
        compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("FAIL rd1_valid: got %b want 1", rd_valid); end
        compared++; if (rd_data !== ab) begin mismatched++; $display("FAIL rd1_data: got %h want %h", rd_data, ab); end
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL rd2_stall_inst: got %h want 0", sa_instruction); end
        repeat (4) tick();
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL rd2_still_stalled: got %h want 0", sa_instruction); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rd2_stall_busy: got %b want 1", busy); end
        compared++; if (rd_data !== ab) begin mismatched++; $display("FAIL rd1_data_held: got %h want %h", rd_data, ab); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        compared++; if (sa_instruction !== 20'h81100) begin mismatched++; $display("FAIL rd2_issue: got %h want 81100", sa_instruction); end
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL rd1_consumed: got %b want 0", rd_valid); end
        tick();
        tick();
        compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("FAIL rd2_valid: got %b want 1", rd_valid); end
        compared++; if (rd_data !== cd) begin mismatched++; $display("FAIL rd2_data: got %h want %h", rd_data, cd); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rd2_busy: got %b want 0", busy); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL rd2_consumed: got %b want 0", rd_valid); end
    endtask

    task automatic test_illegal();
        logic [DB-1:0] d2;
        d2 = {$urandom, $urandom, $urandom, $urandom};
        compared++; if (err_opcode !== 1'b0) begin mismatched++; $display("FAIL ill_err_before: got %b want 0", err_opcode); end
        cmd_valid = 1'b1; cmd_inst = 20'hC1234; cmd_din = '1;
        tick();
        cmd_inst = 20'h10007; cmd_din = d2;
        tick();
        cmd_valid = 1'b0;
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL ill_inst: got %h want 0", sa_instruction); end
        compared++; if (err_opcode !== 1'b1) begin mismatched++; $display("FAIL ill_err: got %b want 1", err_opcode); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ill_busy: got %b want 1", busy); end
        tick();
        compared++; if (sa_instruction !== 20'h10007) begin mismatched++; $display("FAIL ill_next_inst: got %h want 10007", sa_instruction); end
        compared++; if (sa_din !== d2) begin mismatched++; $display("FAIL ill_next_din: got %h want %h", sa_din, d2); end
        tick();
        compared++; if (err_opcode !== 1'b1) begin mismatched++; $display("FAIL ill_err_sticky: got %b want 1", err_opcode); end
    endtask

    task automatic test_reset_mid_hold();
        cmd_valid = 1'b1; cmd_inst = 20'h50000; cmd_din = '1;
        tick();
        cmd_inst = 20'h10001;
        tick();
        cmd_valid = 1'b0;
        repeat (9) tick();
        compared++; if (sa_instruction !== 20'h50000) begin mismatched++; $display("FAIL rst_pre_inst: got %h want 50000", sa_instruction); end
        #3 reset = 1'b1;
        #1;
        compared++; if (sa_instruction !== '0) begin mismatched++; $display("FAIL rst_async_inst: got %h want 0", sa_instruction); end
        compared++; if (sa_din !== '0) begin mismatched++; $display("FAIL rst_async_din: got %h want 0", sa_din); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_async_ready: got %b want 1", cmd_ready); end
        compared++; if (err_opcode !== 1'b0) begin mismatched++; $display("FAIL rst_async_err: got %b want 0", err_opcode); end
        tick();
        reset = 1'b0;
        tick();
        compared++; if (sa_instruction !== '0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_fifo_empty: inst %h busy %b want 0 0", sa_instruction, busy); end
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 700; c++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            op = $urandom_range(0, 15);
            if (op > 8 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 8);
            if ((op == 5 || op == 6) && $urandom_range(0, 2) != 0) op = 1;
            cmd_inst = {4'(op), 16'($urandom)};
            for (int w = 0; w < 4; w++) cmd_din[32*w +: 32] = $urandom;
            rd_ready = ($urandom_range(0, 1) == 1);
            for (int w = 0; w < 10; w++) sa_dout[32*w +: 32] = $urandom;
            tick();
            compared++; if (sa_instruction !== m_inst) begin mismatched++; $display("FAIL rnd_inst c%0d: got %h want %h", c, sa_instruction, m_inst); end
            compared++; if (sa_din !== m_din) begin mismatched++; $display("FAIL rnd_din c%0d: got %h want %h", c, sa_din, m_din); end
            compared++; if (rd_valid !== m_rdv) begin mismatched++; $display("FAIL rnd_rd_valid c%0d: got %b want %b", c, rd_valid, m_rdv); end
            compared++; if (rd_data !== m_rdd) begin mismatched++; $display("FAIL rnd_rd_data c%0d: got %h want %h", c, rd_data, m_rdd); end
            compared++; if (busy !== (q.size() > 0 || m_left > 0)) begin mismatched++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, (q.size() > 0 || m_left > 0)); end
            compared++; if (err_opcode !== m_err) begin mismatched++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_opcode, m_err); end
            compared++; if (cmd_ready !== (q.size() < DEPTH)) begin mismatched++; $display("FAIL rnd_cmd_ready c%0d: got %b want %b", c, cmd_ready, (q.size() < DEPTH)); end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_fifo_full();
        test_read_ub();
        test_illegal();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sa_inst_sequencer.md
# sa_inst_sequencer

Instruction sequencer between the host command interface and `SYSTOLIC_ARRAY`. It queues host instructions with their write data in a FIFO and drives each one onto the array's `instruction`/`din` buses for that opcode's required cycle count. Outside of queued instructions it drives IDLE. It captures `dout` at the end of every READ_UB and returns it through a valid/ready handshake.

## Interface
- `INST_BITS`, 20, instruction width; opcode [19:16], ADDRA [15:8], ADDRB [7:0]
- `OPCODE_BITS`, 4, opcode field width
- `DIN_BITS`, 128, array write-data width (16 × 8-bit)
- `DOUT_BITS`, 320, array read-data width
- `FIFO_DEPTH`, 8, command FIFO entries (power of 2, ≥2)
- `IDLE_CYCLE`, `WRITE_DATA_CYCLE`, `WRITE_WEIGHT_CYCLE`, `LOAD_DATA_CYCLE`, `LOAD_WEIGHT_CYCLE`, `WRITE_RESULT_CYCLE`: default 1 each; hold cycles per opcode, each ≥1
- `MAT_MUL_CYCLE`, 32, hold cycles for MAT_MUL and MAT_MUL_ACC
- `READ_UB_CYCLE`, 2, hold cycles for READ_UB
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: FIFO can accept a command
- `cmd_inst` in INST_BITS: host instruction
- `cmd_din` in DIN_BITS: data paired with the instruction
- `sa_instruction` out INST_BITS: to array `instruction`
- `sa_din` out DIN_BITS: to array `din`
- `sa_dout` in DOUT_BITS: from array `dout`
- `rd_valid` out 1: captured READ_UB data available
- `rd_ready` in 1: host consumes `rd_data`
- `rd_data` out DOUT_BITS: captured read data
- `busy` out 1: FIFO non-empty, or state not S_IDLE
- `err_opcode` out 1: sticky, an illegal opcode was dequeued

## Operation
- Opcodes: IDLE=0, WRITE_DATA=1, WRITE_WEIGHT=2, LOAD_DATA=3, LOAD_WEIGHT=4, MAT_MUL=5, MAT_MUL_ACC=6, WRITE_RESULT=7, READ_UB=8. Values 9–15 are illegal.
- FIFO push on `cmd_valid && cmd_ready`. `cmd_ready = !full`. A full FIFO with a simultaneous pop does not accept; no pass-through.
- State machine:
  - S_IDLE: if FIFO non-empty, pop the head, load `sa_instruction`/`sa_din`, set the hold counter to the opcode's cycle count minus 1, and go to S_HOLD. Exception: a READ_UB head while `rd_valid && !rd_ready` stays in S_IDLE (stall).
  - S_HOLD: decrement the counter. At counter==0:
    - READ_UB: capture `sa_dout` into `rd_data` and set `rd_valid`.
    - Then, if the next head is issuable, pop and load it (back-to-back). Otherwise drive all-zero instruction and go to S_IDLE.
- Illegal opcode: issued as all-zero instruction for 1 cycle; sets `err_opcode`.
- `rd_valid` clears on `rd_valid && rd_ready`. A capture on the same cycle as that clear takes priority: `rd_valid` stays 1 with the new data.
- Hold counter width: $clog2(max cycle param)+1; must not wrap.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

## Timing
- Reset values: `sa_instruction`=0, `sa_din`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `err_opcode`=0, `cmd_ready`=1, FIFO empty, state S_IDLE.
- Reset asserted mid-hold aborts the instruction; outputs go to reset values immediately.
- Command accepted at cycle T into an empty, idle sequencer: appears on `sa_instruction` at T+1 and is held through T+N.
- With a queued successor, the successor appears at T+N+1, with no IDLE gap.
- READ_UB: `sa_dout` is sampled at the rising edge ending the last hold cycle; `rd_valid` is high from the next cycle.
- `cmd_ready` rises the cycle after a pop from a full FIFO.

## Configuration
- `SA_SEQ_STATS_EN` defined: adds outputs `stat_inst_count[31:0]` and `stat_busy_cycles[31:0]`.
  - `stat_inst_count`: instructions issued, including illegal ones.
  - `stat_busy_cycles`: cycles with state S_HOLD.
  - Both saturate at 2^32−1 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single WRITE_DATA (inst 0x1_05_00, din 0x0F0E…00) at T → `sa_instruction`=0x10500 only at T+1; 0 at T+2; `sa_din` matches at T+1.
- Push 8 commands back-to-back at full rate → `cmd_ready` low after the 8th. Ninth command is held off until the first pop, then accepted.
- MAT_MUL then WRITE_RESULT queued → MAT_MUL held exactly 32 cycles, WRITE_RESULT on cycle 33, no gap.
- READ_UB ×2 with `rd_ready`=0 and `sa_dout`=0xAB…:
  - First READ_UB held 2 cycles; `rd_valid`=1 with `rd_data`=0xAB… captured.
  - Second READ_UB stalls with `busy`=1 until `rd_ready` pulses, then issues.
- Opcode 0xC enqueued → one all-zero cycle, `err_opcode`=1 and stays 1; the following valid command issues normally.
- Reset pulse during cycle 10 of a MAT_MUL → `sa_instruction`=0, FIFO empty, `busy`=0 immediately, with no clock edge needed.
